// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and helpers for the multi-cycle shift sequencer.
//               - shift_dir_e : shift direction (left = toward index 0)
//               - seq_state_e : sequencer FSM state encoding
//               - min_step()  : size of the next pass, min(remaining, max)
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    function automatic int unsigned min_step(input int unsigned remaining,
                                             input int unsigned max_mag);
        return (remaining < max_mag) ? remaining : max_mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single shift pass of 0..MAX_SHIFT_MAG bits,
//               left (toward index 0) or right, zero fill or rotate.
// Ports       : i_data [0:LEN-1]  word to shift, index 0 is MSB
//               i_dir             0 = left, 1 = right
//               i_rot             0 = zero fill, 1 = rotate
//               i_amt  [STEP_W]   pass magnitude, never above MAX_SHIFT_MAG
//               o_data [0:LEN-1]  shifted word
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter  int LEN           = 8,
    parameter  int MAX_SHIFT_MAG = 2,
    localparam int STEP_W        = $clog2(MAX_SHIFT_MAG + 1)
) (
    input  logic [0:LEN-1]    i_data,
    input  logic              i_dir,
    input  logic              i_rot,
    input  logic [STEP_W-1:0] i_amt,
    output logic [0:LEN-1]    o_data
);

    logic [0:LEN-1] w_fill;
    logic [31:0]    w_back;
    logic [0:LEN-1] w_left;
    logic [0:LEN-1] w_right;

    // Rotation is a shift OR'd with the word shifted the other way by
    // LEN-amt; with zero fill that second term vanishes. amt=0 gives a
    // back-shift of LEN, which clears the term as required.
    assign w_fill  = i_rot ? i_data : '0;
    assign w_back  = 32'(LEN) - 32'(i_amt);
    assign w_left  = (i_data << i_amt) | (w_fill >> w_back);
    assign w_right = (i_data >> i_amt) | (w_fill << w_back);
    assign o_data  = (i_dir == SHIFT_RIGHT) ? w_right : w_left;

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq
// Description : Multi-cycle shift sequencer. Accepts a word and a shift
//               request of any magnitude, applies it as passes of at most
//               MAX_SHIFT_MAG bits (one per clock) through shift_step, and
//               returns the result over a valid/ready handshake.
// Ports       : clk, rst (sync, active high)
//               in_valid/in_ready, in_data[0:LEN-1], in_dir, in_rot, in_amt
//               out_valid/out_ready, out_data[0:LEN-1], busy
// Options     : SHIFT_SEQ_BACK2BACK_EN - accept a new request in the same
//               cycle the result is taken (no IDLE bubble).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq
    import shift_pkg::*;
#(
    parameter  int LEN           = 8,
    parameter  int MAX_SHIFT_MAG = 2,
    localparam int AMT_W         = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:LEN-1]   in_data,
    input  logic             in_dir,
    input  logic             in_rot,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:LEN-1]   out_data,
    output logic             busy
);

    localparam int               STEP_W     = $clog2(MAX_SHIFT_MAG + 1);
    localparam logic [AMT_W-1:0] c_len      = AMT_W'(LEN);
    localparam logic [AMT_W-1:0] c_rot_mask = AMT_W'(LEN - 1);

    if ((LEN < 1) || ((LEN & (LEN - 1)) != 0)) begin : g_bad_len
        $error("shift_seq: LEN must be a power of two");
    end
    if ((MAX_SHIFT_MAG < 1) || (MAX_SHIFT_MAG > LEN)) begin : g_bad_mag
        $error("shift_seq: MAX_SHIFT_MAG must be in 1..LEN");
    end

    seq_state_e       r_state;
    seq_state_e       w_next_state;
    seq_state_e       w_start_state;
    logic [0:LEN-1]   r_data;
    logic             r_dir;
    logic             r_rot;
    logic [AMT_W-1:0] r_remaining;
    logic [0:LEN-1]   r_out_data;
    logic [AMT_W-1:0] w_amt_eff;
    logic [AMT_W-1:0] w_step;
    logic             w_last;
    logic             w_accept;
    logic [0:LEN-1]   w_pass;

`ifdef SHIFT_SEQ_BACK2BACK_EN
    assign in_ready = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
`else
    assign in_ready = !rst && (r_state == IDLE);
`endif

    assign w_accept = in_valid && in_ready;

    // Rotation only cares about amt mod LEN; a logical shift saturates at
    // LEN, which already clears the word.
    always_comb begin
        w_amt_eff = in_amt;
        if (in_rot) begin
            w_amt_eff = in_amt & c_rot_mask;
        end else if (in_amt > c_len) begin
            w_amt_eff = c_len;
        end
    end

    assign w_step = AMT_W'(min_step(32'(r_remaining), MAX_SHIFT_MAG));
    assign w_last = (r_remaining == w_step);

    shift_step #(
        .LEN          (LEN),
        .MAX_SHIFT_MAG(MAX_SHIFT_MAG)
    ) u_shift_step (
        .i_data(r_data),
        .i_dir (r_dir),
        .i_rot (r_rot),
        .i_amt (STEP_W'(w_step)),
        .o_data(w_pass)
    );

    always_comb begin
        w_next_state  = r_state;
        w_start_state = (w_amt_eff != '0) ? SHIFT : DONE;
        out_valid     = 1'b0;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_start_state;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // w_accept can only be high here in back-to-back builds.
                if (out_ready) begin
                    w_next_state = w_accept ? w_start_state : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_dir       <= 1'b0;
            r_rot       <= 1'b0;
            r_remaining <= '0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_data      <= in_data;
                r_dir       <= in_dir;
                r_rot       <= in_rot;
                r_remaining <= w_amt_eff;
                if (w_amt_eff == '0) begin
                    r_out_data <= in_data;
                end
            end else if (r_state == SHIFT) begin
                r_data      <= w_pass;
                r_remaining <= r_remaining - w_step;
                // Only the completed word is published on out_data.
                if (w_last) begin
                    r_out_data <= w_pass;
                end
            end
        end
    end

    assign out_data = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq
// Description : Self-checking bench for shift_seq (LEN=8, MAX_SHIFT_MAG=2)
//               with a result scoreboard and latency tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    localparam int LEN   = 8;
    localparam int MAX   = 2;
    localparam int AMT_W = 4;
`ifdef SHIFT_SEQ_BACK2BACK_EN
    localparam int B2B_GAP = 0;
`else
    localparam int B2B_GAP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:LEN-1]   in_data;
    logic             in_dir;
    logic             in_rot;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [0:LEN-1]   out_data;
    logic             busy;

    shift_seq #(
        .LEN          (LEN),
        .MAX_SHIFT_MAG(MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .in_rot   (in_rot),
        .in_amt   (in_amt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:LEN-1] data;
        int             k;
        int             acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bit-by-bit reference: out[i] takes in[i+eff] (left) or in[i-eff] (right).
    function automatic exp_t model(input logic [0:LEN-1] d, input logic dir,
                                   input logic rot, input int amt);
        exp_t           e;
        int             eff;
        int             src;
        logic [0:LEN-1] r;
        eff = rot ? (amt % LEN) : ((amt > LEN) ? LEN : amt);
        for (int i = 0; i < LEN; i++) begin
            src = dir ? (i - eff) : (i + eff);
            if (rot)                         r[i] = d[(src + LEN) % LEN];
            else if (src >= 0 && src < LEN)  r[i] = d[src];
            else                             r[i] = 1'b0;
        end
        e.data = r;
        e.k    = (eff + MAX - 1) / MAX;
        e.acc  = 0;
        return e;
    endfunction

    // Call at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [0:LEN-1] d, input logic dir, input logic rot,
                        input int amt, output int acc);
        exp_t e;
        int   waited;
        waited   = 0;
        acc      = -1;
        e        = model(d, dir, rot, amt);
        in_data  = d;
        in_dir   = dir;
        in_rot   = rot;
        in_amt   = AMT_W'(amt);
        in_valid = 1'b1;
        while (acc < 0 && waited < 100) begin
            #1;
            if (in_ready) begin
                acc   = cyc + 1;
                e.acc = acc;
                q.push_back(e);
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        if (acc < 0) check_eq("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = LEN'($urandom);
        in_dir   = 1'($urandom);
        in_rot   = 1'($urandom);
        in_amt   = AMT_W'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            check_eq("drain_timeout", 64'(q.size()), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Output monitor: latency on the first valid cycle of each result,
    // data on the handshake.
    logic prev_v  = 1'b0;
    logic prev_hs = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (out_valid && (!prev_v || prev_hs)) begin
                if (q.size() == 0) check_eq("spurious_valid", 1, 0);
                else               check_eq("latency", 64'(cyc - q[0].acc), 64'(q[0].k));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                check_eq("out_data", 64'(out_data), 64'(e.data));
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc;
        int acc2;
        int hs;
        int w;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = '1;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        in_amt    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 0);
        check_eq("rst_out_valid", 64'(out_valid), 0);
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_out_data", 64'(out_data), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_eq("idle_in_ready", 64'(in_ready), 1);
        @(negedge clk);

        // Directed cases
        send(8'b00000011, 1'b0, 1'b0, 3, acc); drain();
        send(8'b10000001, 1'b1, 1'b1, 3, acc); drain();
        send(8'b10000001, 1'b1, 1'b1, 9, acc); drain();
        send(8'b10110010, 1'b0, 1'b0, 0, acc); drain();
        send(8'b11111111, 1'b0, 1'b0, 9, acc); drain();
        send(8'b11010110, 1'b1, 1'b0, 5, acc); drain();
        send(8'b11010110, 1'b0, 1'b1, 8, acc); drain();

        // Streamed random requests
        for (int i = 0; i < 12; i++) begin
            send(LEN'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15), acc);
        end
        drain();

        // Backpressure, then the pending request against the handshake cycle
        out_ready = 1'b0;
        send(8'b01100000, 1'b1, 1'b0, 1, acc);
        in_data  = 8'b11110000;
        in_dir   = 1'b0;
        in_rot   = 1'b1;
        in_amt   = 4'd2;
        in_valid = 1'b1;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_reach_done", 64'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_valid", 64'(out_valid), 1);
            check_eq("bp_data", 64'(out_data), 64'(8'b00110000));
            check_eq("bp_in_ready", 64'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        hs = cyc + 1;
        send(8'b11110000, 1'b0, 1'b1, 2, acc2);
        check_eq("b2b_accept_gap", 64'(acc2 - hs), 64'(B2B_GAP));
        drain();

        // Reset in the middle of a shift
        send(8'b10101010, 1'b0, 1'b0, 8, acc);
        #1;
        check_eq("busy_in_shift", 64'(busy), 1);
        rst = 1'b1;
        q.delete();
        #1;
        check_eq("midrst_in_ready", 64'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 0);
        check_eq("midrst_out_valid", 64'(out_valid), 0);
        check_eq("midrst_out_data", 64'(out_data), 0);
        repeat (6) @(negedge clk);
        send(8'b00000011, 1'b0, 1'b0, 3, acc); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
